// File: rtl/fp_add_arbiter_if.sv
// Request, shared-adder and response signals of the two-requester FP-add arbiter.
// slave is the arbiter's view; master is the requesters/adder/consumer side.
`timescale 1ns/1ps
interface fp_add_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_sum;
  logic        resp_ready;
  logic        busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  add_sum, resp_ready,
    output req0_ready, req1_ready, add_a, add_b,
    output resp_valid, resp_id, resp_sum, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output add_sum, resp_ready,
    input  req0_ready, req1_ready, add_a, add_b,
    input  resp_valid, resp_id, resp_sum, busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp_adder between two requesters.
// One operation in flight: IDLE -> WAIT (ADD_LATENCY cycles) -> RESP -> IDLE.
`timescale 1ns/1ps
module fp_add_arbiter #(
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_add_arbiter_if.slave bus
);

  localparam logic [3:0] LAT = 4'(ADD_LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        ptr;
  logic [3:0]  cnt;
  logic [31:0] a_q, b_q, sum_q;
  logic        id_q;

  logic        grant;
  logic        rdy0, rdy1;
  logic        accept;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        // A lone requester wins outright; the pointer only breaks ties.
        if (bus.req0_valid && bus.req1_valid) grant = ptr;
        else                                  grant = bus.req1_valid;
        // Gated by rst_n so no request is acknowledged while held in reset.
        rdy0   = rst_n && bus.req0_valid && !grant;
        rdy1   = rst_n && bus.req1_valid &&  grant;
        accept = rdy0 || rdy1;
        if (accept) state_nx = WAIT;
      end
      WAIT: begin
        if (cnt <= 4'd1) state_nx = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering. There are no memories;
  // every register here is small enough to reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sum_q <= 32'd0;
      id_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q  <= grant ? bus.req1_a : bus.req0_a;
        b_q  <= grant ? bus.req1_b : bus.req0_b;
        id_q <= grant;
        ptr  <= ~grant;
        cnt  <= LAT;
      end
      if (state == WAIT) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        if (state_nx == RESP) sum_q <= bus.add_sum;
      end
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.add_a      = a_q;
  assign bus.add_b      = b_q;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = sum_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: two instances (latency 1 and 4) with a table-driven
// adder model, a scoreboard queue fed by stimulus and drained by monitors.
`timescale 1ns/1ps
module tb_fp_add_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  fp_add_arbiter_if ifa ();
  fp_add_arbiter_if ifb ();

  fp_add_arbiter #(.ADD_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifa));
  fp_add_arbiter #(.ADD_LATENCY(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Hand-computed sums for the operand pairs used below.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'hBF800000, 32'h3FC00000}: return 32'h3F000000;
      {32'h3E4CCCCD, 32'h3F800000}: return 32'h3F99999A;
      {32'hBE4CCCCD, 32'h40200000}: return 32'h40133333;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  assign ifa.add_sum = fadd(ifa.add_a, ifa.add_b);
  assign ifb.add_sum = fadd(ifb.add_a, ifb.add_b);

  typedef struct {
    int          unit;
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic prev_rv [2];
  int   acc_edge[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int u, input logic id, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] sum);
    exp_t e;
    e.unit = u; e.id = id; e.a = a; e.b = b; e.sum = sum;
    sbq.push_back(e);
  endtask

  // Monitor body, run at every falling edge for one instance.
  task automatic mon(input int u, input logic r0v, input logic r0r, input logic r1v,
                     input logic r1r, input logic bsy, input logic rv, input logic rr,
                     input logic rid, input logic [31:0] rs, input logic [31:0] aa,
                     input logic [31:0] ab);
    exp_t e;
    int   lat;
    lat = (u == 0) ? 1 : 4;
    check($sformatf("u%0d_ready_onehot", u), 32'(r0r & r1r), 32'd0);
    if (bsy) check($sformatf("u%0d_ready_low_busy", u), 32'({r0r, r1r}), 32'd0);
    if (bsy && sbq.size() > 0 && sbq[0].unit == u) begin
      check($sformatf("u%0d_add_a_hold", u), aa, sbq[0].a);
      check($sformatf("u%0d_add_b_hold", u), ab, sbq[0].b);
    end
    if (rv && !prev_rv[u])
      check($sformatf("u%0d_latency", u), 32'(cyc - acc_edge[u]), 32'(lat));
    if (rv && sbq.size() > 0 && sbq[0].unit == u) begin
      check($sformatf("u%0d_resp_sum", u), rs, sbq[0].sum);
      check($sformatf("u%0d_resp_id", u), 32'(rid), 32'(sbq[0].id));
    end
    if (rv && rr) begin
      if (sbq.size() == 0) begin
        check($sformatf("u%0d_unexpected_resp", u), 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        check($sformatf("u%0d_resp_unit", u), 32'(u), 32'(e.unit));
      end
    end
    if ((r0v && r0r) || (r1v && r1r)) acc_edge[u] = cyc + 1;
    prev_rv[u] = rv;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      prev_rv[0] = 1'b0;
    end else begin
      mon(0, ifa.req0_valid, ifa.req0_ready, ifa.req1_valid, ifa.req1_ready, ifa.busy,
          ifa.resp_valid, ifa.resp_ready, ifa.resp_id, ifa.resp_sum, ifa.add_a, ifa.add_b);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      prev_rv[1] = 1'b0;
    end else begin
      mon(1, ifb.req0_valid, ifb.req0_ready, ifb.req1_valid, ifb.req1_ready, ifb.busy,
          ifb.resp_valid, ifb.resp_ready, ifb.resp_id, ifb.resp_sum, ifb.add_a, ifb.add_b);
    end
  end

  task automatic set_req(input int u, input int r, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
    if (u == 0) begin
      if (r == 0) begin ifa.req0_valid = v; ifa.req0_a = a; ifa.req0_b = b; end
      else        begin ifa.req1_valid = v; ifa.req1_a = a; ifa.req1_b = b; end
    end else begin
      if (r == 0) begin ifb.req0_valid = v; ifb.req0_a = a; ifb.req0_b = b; end
      else        begin ifb.req1_valid = v; ifb.req1_a = a; ifb.req1_b = b; end
    end
  endtask

  function automatic logic rdy(input int u, input int r);
    if (u == 0) return (r == 0) ? ifa.req0_ready : ifa.req1_ready;
    return (r == 0) ? ifb.req0_ready : ifb.req1_ready;
  endfunction

  task automatic chk_zero(input int u, input string tag);
    if (u == 0) begin
      check({tag, "_u0_add_a"}, ifa.add_a, 32'd0);
      check({tag, "_u0_add_b"}, ifa.add_b, 32'd0);
      check({tag, "_u0_resp_sum"}, ifa.resp_sum, 32'd0);
      check({tag, "_u0_ctrl"}, 32'({ifa.resp_valid, ifa.resp_id, ifa.busy,
                                    ifa.req0_ready, ifa.req1_ready}), 32'd0);
    end else begin
      check({tag, "_u1_add_a"}, ifb.add_a, 32'd0);
      check({tag, "_u1_add_b"}, ifb.add_b, 32'd0);
      check({tag, "_u1_resp_sum"}, ifb.resp_sum, 32'd0);
      check({tag, "_u1_ctrl"}, 32'({ifb.resp_valid, ifb.resp_id, ifb.busy,
                                    ifb.req0_ready, ifb.req1_ready}), 32'd0);
    end
  endtask

  // Returns one time unit after the accepting edge.
  task automatic wait_accept(input int u, input int r, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (rdy(u, r)) seen = 1'b1;
    end
    if (seen) begin
      @(posedge clk);
      #1;
    end else begin
      check({tag, "_accept_timeout"}, 32'(seen), 32'd1);
    end
  endtask

  // Returns one time unit after the edge completing the last expected handshake.
  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      if (sbq.size() == 0) done = 1'b1;
    end
    #1;
    if (!done) check({tag, "_drain_timeout"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    prev_rv[0] = 1'b0; prev_rv[1] = 1'b0;
    acc_edge[0] = 0;   acc_edge[1] = 0;
    for (int u = 0; u < 2; u++)
      for (int r = 0; r < 2; r++) set_req(u, r, 1'b0, 32'd0, 32'd0);
    ifa.resp_ready = 1'b1;
    ifb.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single add, latency 1
    @(posedge clk); #1;
    push(0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_req(0, 0, 1'b1, 32'h3F800000, 32'h40000000);
    wait_accept(0, 0, "single");
    set_req(0, 0, 1'b0, 32'd0, 32'd0);
    wait_drain("single");

    // Backpressure: response held 10 cycles while req1 waits
    push(0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
    push(0, 1'b1, 32'h3E4CCCCD, 32'h3F800000, 32'h3F99999A);
    ifa.resp_ready = 1'b0;
    set_req(0, 0, 1'b1, 32'h3F800000, 32'h40000000);
    wait_accept(0, 0, "bp");
    set_req(0, 0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1, 1'b1, 32'h3E4CCCCD, 32'h3F800000);
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk);
      if (ifa.resp_valid) seen = 1'b1;
    end
    check("bp_resp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_busy", 32'(ifa.busy), 32'd1);
      check("bp_resp_valid", 32'(ifa.resp_valid), 32'd1);
      check("bp_readys", 32'({ifa.req0_ready, ifa.req1_ready}), 32'd0);
    end
    @(posedge clk); #1;
    ifa.resp_ready = 1'b1;
    @(negedge clk);   // handshake pending at the next edge
    @(negedge clk);   // one edge later: back in IDLE
    check("bp_idle_busy", 32'(ifa.busy), 32'd0);
    check("bp_idle_req1_ready", 32'(ifa.req1_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1, 1'b0, 32'd0, 32'd0);
    wait_drain("bp");

    // Contention from reset exit: pointer alternates over 4 pairs
    set_req(0, 0, 1'b1, 32'hBF800000, 32'h3FC00000);
    set_req(0, 1, 1'b1, 32'h3E4CCCCD, 32'h3F800000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk_zero(0, "rst_contend");
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b0, 32'hBF800000, 32'h3FC00000, 32'h3F000000);
      push(0, 1'b1, 32'h3E4CCCCD, 32'h3F800000, 32'h3F99999A);
    end
    rst_n = 1'b1;
    wait_drain("contend");
    set_req(0, 0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1, 1'b0, 32'd0, 32'd0);

    // Latency sweep on the ADD_LATENCY=4 instance
    push(1, 1'b0, 32'hBE4CCCCD, 32'h40200000, 32'h40133333);
    set_req(1, 0, 1'b1, 32'hBE4CCCCD, 32'h40200000);
    wait_accept(1, 0, "lat4");
    set_req(1, 0, 1'b0, 32'd0, 32'd0);
    wait_drain("lat4");

    // Reset during WAIT: operation dropped, pointer back to 0
    push(1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
    set_req(1, 0, 1'b1, 32'h3F800000, 32'h40000000);
    wait_accept(1, 0, "midrst");
    set_req(1, 0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("midrst_in_wait", 32'({ifb.busy, ifb.resp_valid}), 32'b10);
    rst_n = 1'b0;
    #1;
    chk_zero(1, "midrst");
    chk_zero(0, "midrst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(ifb.resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    push(1, 1'b0, 32'hBF800000, 32'h3FC00000, 32'h3F000000);
    push(1, 1'b1, 32'h3E4CCCCD, 32'h3F800000, 32'h3F99999A);
    set_req(1, 0, 1'b1, 32'hBF800000, 32'h3FC00000);
    set_req(1, 1, 1'b1, 32'h3E4CCCCD, 32'h3F800000);
    rst_n = 1'b1;
    wait_drain("postrst");
    set_req(1, 0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1, 1'b0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'({ifa.busy, ifb.busy}), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
